gshare_btb_predictor: RTL

//  Parametrised next-PC predictor for the 16-bit pipelined CPU. Sits beside the IF stage.
//  - Lookup is combinational in IF.
//  - BTB entries are allocated in ID.
//  - Direction counters and global history are trained when the branch resolves in ID/EX.
//  - Adds selectable modes (static, BTB-only, 2-bit bimodal, gshare) and branch statistics counters.

---
 rtl/gshare_btb_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/gshare_btb_predictor.sv
// Next-PC predictor beside IF: direct-mapped BTB plus a 2-bit PHT indexed by PC or PC^history.
// MODE selects static, BTB-only, bimodal or gshare prediction; branch statistics always count.
module gshare_btb_predictor #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned BTB_IDX_SIZE = 8,
   parameter int unsigned MODE         = 2,
   parameter int unsigned GHR_LEN      = 8,
   parameter logic [1:0]  CNT_INIT     = 2'b01
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [WORD_SIZE-1:0]    pc_IF,
   output logic                    tag_match_IF,
   output logic                    taken_IF,
   output logic [WORD_SIZE-1:0]    branch_predicted_pc_IF,
   output logic [BTB_IDX_SIZE-1:0] pred_index_IF,
   input  logic                    update_tag,
   input  logic [WORD_SIZE-1:0]    pc_for_btb_update,
   input  logic [WORD_SIZE-1:0]    branch_target_for_btb_update,
   input  logic                    update_bht,
   input  logic [BTB_IDX_SIZE-1:0] bht_index,
   input  logic                    branch_taken,
   input  logic                    branch_correct,
   output logic [WORD_SIZE-1:0]    num_branch,
   output logic [WORD_SIZE-1:0]    num_branch_miss,
   output logic [GHR_LEN-1:0]      ghr
);

   localparam int unsigned IDX     = BTB_IDX_SIZE;
   localparam int unsigned TAG_W   = WORD_SIZE - IDX;
   localparam int unsigned ENTRIES = 1 << IDX;

   logic                 valid_q  [ENTRIES];
   logic [TAG_W-1:0]     tag_q    [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [1:0]           pht_q    [ENTRIES];
   logic [GHR_LEN-1:0]   ghr_q;
   logic [WORD_SIZE-1:0] num_branch_q;
   logic [WORD_SIZE-1:0] num_miss_q;

   logic [IDX-1:0] btb_idx;
   logic [IDX-1:0] pht_idx;
   logic [IDX-1:0] wr_idx;
   logic [1:0]     pht_cur;
   logic [1:0]     pht_nxt;

   always_comb begin
      btb_idx = pc_IF[IDX-1:0];
      pht_idx = (MODE == 3) ? (btb_idx ^ IDX'(ghr_q)) : btb_idx;
      tag_match_IF = (MODE != 0) && valid_q[btb_idx] &&
                     (tag_q[btb_idx] == pc_IF[WORD_SIZE-1:IDX]);
      taken_IF = 1'b0;
      if (MODE == 1) begin
         taken_IF = tag_match_IF;
      end else if (MODE >= 2) begin
         taken_IF = tag_match_IF && pht_q[pht_idx][1];
      end
      branch_predicted_pc_IF = taken_IF ? target_q[btb_idx] : pc_IF + WORD_SIZE'(1);
      pred_index_IF = pht_idx;
   end

   // Saturating 2-bit counter step for the entry being trained
   always_comb begin
      wr_idx  = pc_for_btb_update[IDX-1:0];
      pht_cur = pht_q[bht_index];
      pht_nxt = pht_cur;
      if (branch_taken && pht_cur != 2'b11) begin
         pht_nxt = pht_cur + 2'b01;
      end else if (!branch_taken && pht_cur != 2'b00) begin
         pht_nxt = pht_cur - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            pht_q[i]   <= CNT_INIT;
         end
         ghr_q        <= '0;
         num_branch_q <= '0;
         num_miss_q   <= '0;
      end else begin
         if (update_tag && MODE != 0) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= pc_for_btb_update[WORD_SIZE-1:IDX];
            target_q[wr_idx] <= branch_target_for_btb_update;
         end
         if (update_bht) begin
            if (MODE >= 2) begin
               pht_q[bht_index] <= pht_nxt;
            end
            // Truncating {ghr, taken} drops the oldest bit; also covers GHR_LEN = 1
            if (MODE == 3) begin
               ghr_q <= GHR_LEN'({ghr_q, branch_taken});
            end
            if (num_branch_q != '1) begin
               num_branch_q <= num_branch_q + WORD_SIZE'(1);
            end
            if (!branch_correct && num_miss_q != '1) begin
               num_miss_q <= num_miss_q + WORD_SIZE'(1);
            end
         end
      end
   end

   assign num_branch      = num_branch_q;
   assign num_branch_miss = num_miss_q;
   assign ghr             = ghr_q;

endmodule
